// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in / serial-out shifter. A WIDTH-bit word accepted
//                on a din_valid/din_ready handshake is emitted MSB first, one
//                bit per clock, on ser_out with ser_valid high. A new word
//                may be accepted in the final output cycle of the current
//                word, so back-to-back words form a gap-free stream.
//  Option      : PISO_PARITY_EN - when defined, an even-parity bit (XOR of
//                the captured word) follows the data bits, giving a word
//                period of WIDTH+1 cycles instead of WIDTH.
//  Ports       : clk       - rising-edge clock
//                rstn      - asynchronous active-low reset
//                din       - parallel word to serialize
//                din_valid - din holds a word to load
//                din_ready - block accepts din this cycle
//                ser_out   - serial bit stream (registered)
//                ser_valid - ser_out carries a valid bit (registered)
//                busy      - a word is being shifted out
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy
);

    localparam int               C_CNT_W    = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_shift;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_ser_out;
    logic                 r_ser_valid;

    state_t               w_nxt_state;
    logic [WIDTH-1:0]     w_nxt_shift;
    logic [C_CNT_W-1:0]   w_nxt_cnt;
    logic                 w_nxt_ser_out;
    logic                 w_nxt_ser_valid;

    logic                 w_last_data;
    logic                 w_final;
    logic                 w_accept;

`ifdef PISO_PARITY_EN
    logic                 r_par;
    logic                 w_nxt_par;
`endif

    // Counter reaching zero in SHIFT means the last data bit is on ser_out.
    assign w_last_data = (r_state == SHIFT) && (r_cnt == '0);

`ifdef PISO_PARITY_EN
    assign w_final = (r_state == PARITY);
`else
    assign w_final = w_last_data;
`endif

    // Ready depends on state and counter only, never on din_valid.
    assign din_ready = (r_state == IDLE) || w_final;
    assign w_accept  = din_valid && din_ready;
    assign busy      = (r_state != IDLE);
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_shift     = r_shift;
        w_nxt_cnt       = r_cnt;
        w_nxt_ser_out   = r_ser_out;
        w_nxt_ser_valid = r_ser_valid;
`ifdef PISO_PARITY_EN
        w_nxt_par       = r_par;
`endif

        if (w_accept) begin
            // MSB goes straight to the output register; the shift register
            // keeps the remaining bits left-aligned.
            w_nxt_state     = SHIFT;
            w_nxt_shift     = {din[WIDTH-2:0], 1'b0};
            w_nxt_cnt       = C_CNT_LAST;
            w_nxt_ser_out   = din[WIDTH-1];
            w_nxt_ser_valid = 1'b1;
`ifdef PISO_PARITY_EN
            w_nxt_par       = ^din;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    w_nxt_ser_out   = 1'b0;
                    w_nxt_ser_valid = 1'b0;
                end
                SHIFT: begin
                    if (r_cnt != '0) begin
                        w_nxt_ser_out   = r_shift[WIDTH-1];
                        w_nxt_shift     = {r_shift[WIDTH-2:0], 1'b0};
                        w_nxt_cnt       = r_cnt - C_CNT_W'(1);
                        w_nxt_ser_valid = 1'b1;
                    end else begin
`ifdef PISO_PARITY_EN
                        w_nxt_state     = PARITY;
                        w_nxt_ser_out   = r_par;
                        w_nxt_ser_valid = 1'b1;
`else
                        w_nxt_state     = IDLE;
                        w_nxt_ser_out   = 1'b0;
                        w_nxt_ser_valid = 1'b0;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    w_nxt_state     = IDLE;
                    w_nxt_ser_out   = 1'b0;
                    w_nxt_ser_valid = 1'b0;
                end
`endif
                default: begin
                    w_nxt_state     = IDLE;
                    w_nxt_ser_out   = 1'b0;
                    w_nxt_ser_valid = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_shift     <= w_nxt_shift;
            r_cnt       <= w_nxt_cnt;
            r_ser_out   <= w_nxt_ser_out;
            r_ser_valid <= w_nxt_ser_valid;
`ifdef PISO_PARITY_EN
            r_par       <= w_nxt_par;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Scoreboard bench for piso_serializer (WIDTH=8 and WIDTH=4
//                instances). Stimulus pushes expected serial bits into a
//                queue; a monitor pops and compares on every valid bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int PER  = 8 + P;
    localparam int PER4 = 4 + P;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready, ser_out, ser_valid, busy;

    logic [3:0] din4 = 4'h0;
    logic       din_valid4 = 1'b0;
    logic       din_ready4, ser_out4, ser_valid4, busy4;

    int         n_chk  = 0;
    int         n_pass = 0;
    bit         exp_q[$];
    logic       m_exp;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8)) u_dut (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .busy(busy)
    );

    piso_serializer #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .din(din4), .din_valid(din_valid4),
        .din_ready(din_ready4), .ser_out(ser_out4), .ser_valid(ser_valid4),
        .busy(busy4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream for one word: hand-supplied word bits MSB first, then
    // the hand-computed parity bit when parity is built in.
    task automatic push_word(input logic [7:0] w, input logic par);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
        if (P == 1) exp_q.push_back(par);
    endtask

    // Monitor: every valid bit must match the head of the queue.
    always @(negedge clk) begin
        if (ser_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid_bit", 32'(ser_out), 32'hDEAD);
            end else begin
                m_exp = exp_q.pop_front();
                chk("ser_out_bit", 32'(ser_out), 32'(m_exp));
            end
        end
    end

    task automatic idle_checks(input string name);
        chk({name, "_idle_valid"}, 32'(ser_valid), 0);
        chk({name, "_idle_out"},   32'(ser_out),   0);
        chk({name, "_idle_busy"},  32'(busy),      0);
        chk({name, "_idle_ready"}, 32'(din_ready), 1);
    endtask

    task automatic single(input logic [7:0] w, input logic par, input string name);
        din       = w;
        din_valid = 1'b1;
        chk({name, "_ready_c0"}, 32'(din_ready), 1);
        push_word(w, par);
        tick();
        din_valid = 1'b0;
        din       = ~w;                 // later din changes must not leak out
        for (int c = 1; c <= PER; c++) begin
            chk({name, "_ready"}, 32'(din_ready), 32'(c == PER));
            chk({name, "_busy"},  32'(busy), 1);
            chk({name, "_valid"}, 32'(ser_valid), 1);
            tick();
        end
        idle_checks(name);
    endtask

    task automatic two_words(input logic [7:0] a, input logic pa,
                             input logic [7:0] b, input logic pb,
                             input string name, input bit noise);
        din       = a;
        din_valid = 1'b1;
        chk({name, "_ready_c0"}, 32'(din_ready), 1);
        push_word(a, pa);
        push_word(b, pb);
        tick();
        for (int c = 1; c <= 2 * PER; c++) begin
            if (c == 1) begin
                din       = noise ? 8'h0F : b;
                din_valid = 1'b1;
            end
            if (c == 3) din = b;
            if (c == PER + 1) begin
                din_valid = 1'b0;
                din       = 8'h00;
            end
            chk({name, "_ready"}, 32'(din_ready), 32'((c == PER) || (c == 2 * PER)));
            chk({name, "_gapfree"}, 32'(ser_valid), 1);
            tick();
        end
        idle_checks(name);
    endtask

    initial begin
        logic [3:0] exp4;
        exp4 = 4'b1011;

        // Reset asserted from time zero: outputs forced before any edge.
        #3;
        chk("rst_valid", 32'(ser_valid), 0);
        chk("rst_out",   32'(ser_out),   0);
        chk("rst_busy",  32'(busy),      0);
        chk("rst_ready", 32'(din_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        idle_checks("post_rst");

        single(8'hB0, 1'b1, "w_b0");
        single(8'h07, 1'b1, "w_07");
        two_words(8'hA5, 1'b0, 8'h3C, 1'b0, "b2b", 1'b0);
        two_words(8'hF0, 1'b0, 8'h55, 1'b0, "stall", 1'b1);

        // Reset in the middle of 8'hFF, just after bit 3 has been shown.
        din       = 8'hFF;
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(1'b1);
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_valid", 32'(ser_valid), 0);
        chk("midrst_busy",  32'(busy), 0);
        chk("midrst_ready", 32'(din_ready), 1);
        chk("midrst_bits_consumed", 32'(exp_q.size()), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("after_rst_out",   32'(ser_out),   0);
            chk("after_rst_valid", 32'(ser_valid), 0);
            chk("after_rst_ready", 32'(din_ready), 1);
        end

        // WIDTH=4 instance: 4'hB -> 1,0,1,1 (+ parity 1).
        din4       = 4'hB;
        din_valid4 = 1'b1;
        chk("w4_ready_c0", 32'(din_ready4), 1);
        tick();
        din_valid4 = 1'b0;
        din4       = 4'h0;
        for (int c = 1; c <= PER4; c++) begin
            chk("w4_valid", 32'(ser_valid4), 1);
            chk("w4_out", 32'(ser_out4), (c <= 4) ? 32'(exp4[4 - c]) : 32'd1);
            chk("w4_ready", 32'(din_ready4), 32'(c == PER4));
            tick();
        end
        chk("w4_idle_valid", 32'(ser_valid4), 0);
        chk("w4_idle_out",   32'(ser_out4),   0);
        chk("w4_idle_busy",  32'(busy4),      0);

        tick();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-005 The block SHALL have port din_valid  input  1  din holds a word to load.
REQ-006 The block SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-007 The block SHALL have port ser_out  output  1  serial bit stream to the downstream sequence detector input.
REQ-008 The block SHALL have port ser_valid  output  1  ser_out carries a valid bit this cycle.
REQ-009 The block SHALL have port busy  output  1  a word is being shifted out.

Function
REQ-010 A word SHALL be accepted on a rising clk edge where din_valid=1 and din_ready=1; there are no other loads.
REQ-011 The FSM SHALL have states IDLE, SHIFT and PARITY; PARITY exists only when PISO_PARITY_EN is defined.
REQ-012 Transitions SHALL be: IDLE->SHIFT on accept; SHIFT->SHIFT while bits remain; SHIFT->PARITY after the last data bit when parity is enabled; last data or parity cycle->SHIFT on accept, else ->IDLE.
REQ-013 Output SHALL be MSB first: cycle n (n=1..WIDTH) after the accept edge carries ser_out=din[WIDTH-n] with ser_valid=1.
REQ-014 ser_out and ser_valid SHALL be driven directly from registers; din_ready SHALL be combinational from state and bit counter only (no din_valid path).
REQ-015 din_ready SHALL be 1 in IDLE and in the final output cycle of a word (last data bit, or parity bit when enabled), and 0 otherwise.
REQ-016 An accept in the final output cycle SHALL make the new word's MSB appear in the immediately following cycle, giving a gap-free stream.
REQ-017 In IDLE, ser_valid SHALL be 0 and ser_out SHALL be 0.
REQ-018 busy SHALL be 1 in SHIFT and PARITY and 0 in IDLE.
REQ-019 The bit counter SHALL be $clog2(WIDTH) bits wide, reload to WIDTH-1 on accept, decrement per shifted bit and never wrap below 0.
REQ-020 din SHALL be captured into the shift register at accept; later din changes SHALL NOT affect output.
REQ-021 din_valid asserted while din_ready=0 SHALL be ignored with no state change; upstream holds din.

Reset
REQ-022 rstn=0 SHALL immediately, regardless of clk, force state=IDLE, ser_out=0, ser_valid=0, busy=0, shift register and counter to 0.
REQ-023 Reset asserted mid-word SHALL discard the remaining bits; no partial word resumes after release.
REQ-024 The first rising edge with rstn=1 SHALL present din_ready=1 and MAY accept a word.

Configuration
REQ-025 Macro PISO_PARITY_EN SHALL be the only compile-time option.
REQ-026 With PISO_PARITY_EN defined, one extra cycle SHALL follow the WIDTH data bits carrying ser_out=XOR of the captured word (even parity) with ser_valid=1; word period is WIDTH+1 cycles.
REQ-027 Without PISO_PARITY_EN, the PARITY state and parity logic SHALL be absent and word period is WIDTH cycles.

Verification
REQ-028 WIDTH=8, no parity: accept 8'hB0 -> cycles 1..8 ser_out=1,0,1,1,0,0,0,0, ser_valid=1; cycle 9 ser_valid=0, din_ready=1.
REQ-029 Back-to-back: 8'hA5 then 8'h3C with din_valid held high -> 16 contiguous valid bits 1010_0101_0011_1100, din_ready high only in cycles 0, 8 and 16.
REQ-030 PISO_PARITY_EN, accept 8'h07 -> bits 0,0,0,0,0,1,1,1 then parity bit 1; din_ready=1 only in the parity cycle.
REQ-031 Reset mid-word: accept 8'hFF, assert rstn=0 between clock edges after bit 3 -> ser_valid=0 and busy=0 immediately; after release no further 1s appear until a new accept.
REQ-032 Stall: din_valid=1 with 8'h55 while busy shifting 8'hF0 -> din change ignored, 8'h55 accepted only at the final bit of 8'hF0, output 1111_0000_0101_0101 gap-free.
REQ-033 WIDTH=4 build: accept 4'hB -> ser_out=1,0,1,1 in cycles 1..4, then idle.
